// File: rtl/getir1.sv
// First fetch stage: owns the program counter, issues word-aligned requests to the L1
// instruction cache and queues issued PS values in order for getir2.
module getir1 #(
    parameter int unsigned           PS_BIT        = 32,
    parameter logic [PS_BIT-1:0]     RESET_PS      = 32'h4000_0000,
    parameter int unsigned           FIFO_DERINLIK = 2
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    output logic [PS_BIT-1:0] l1b_istek_ps_o,
    output logic              l1b_istek_gecerli_o,
    input  logic              l1b_istek_hazir_i,
    output logic              g1_istek_yapildi_o,
    output logic [PS_BIT-1:0] g2_ps_o,
    output logic              g2_ps_gecerli_o,
    input  logic              g2_ps_hazir_i,
    input  logic [PS_BIT-1:0] g2_dallanma_ps_i,
    input  logic              g2_dallanma_gecerli_i,
    input  logic [PS_BIT-1:0] yurut_ps_i,
    input  logic              yurut_hatali_tahmin_i,
    input  logic              cek_duraklat_i
);

    localparam int unsigned PTR_W = (FIFO_DERINLIK > 1) ? $clog2(FIFO_DERINLIK) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DERINLIK + 1);
    localparam logic [CNT_W-1:0] DERINLIK = CNT_W'(FIFO_DERINLIK);
    localparam logic [PTR_W-1:0] SON_PTR  = PTR_W'(FIFO_DERINLIK - 1);

    localparam logic [1:0] G1_BOSTA = 2'd0;
    localparam logic [1:0] G1_ISTEK = 2'd1;
    localparam logic [1:0] G1_DOLU  = 2'd2;

    logic [1:0]        durum_q, durum_d;
    logic [PS_BIT-1:0] ps_q, ps_d;
    logic [CNT_W-1:0]  sayac_q, sayac_d;
    logic [PTR_W-1:0]  yaz_ptr_q, yaz_ptr_d;
    logic [PTR_W-1:0]  oku_ptr_q, oku_ptr_d;
    logic [PS_BIT-1:0] fifo_q [FIFO_DERINLIK];

    logic              yonlendir;
    logic [PS_BIT-1:0] hedef;
    logic [PS_BIT-1:0] hizali_ps;
    logic              istek_gecerli;
    logic              el_sikisma;
    logic              cikar;

    always_comb begin
        yonlendir     = !cek_duraklat_i && (yurut_hatali_tahmin_i || g2_dallanma_gecerli_i);
        hedef         = yurut_hatali_tahmin_i ? yurut_ps_i : g2_dallanma_ps_i;
        hizali_ps     = {ps_q[PS_BIT-1:2], 2'b00};
        // Eligibility looks only at the registered count, never at g2_ps_hazir_i.
        istek_gecerli = (durum_q == G1_ISTEK) && (sayac_q < DERINLIK) && !yonlendir;
        el_sikisma    = istek_gecerli && l1b_istek_hazir_i;
        cikar         = (sayac_q != '0) && g2_ps_hazir_i && !yonlendir;
    end

    always_comb begin
        ps_d      = ps_q;
        sayac_d   = sayac_q;
        yaz_ptr_d = yaz_ptr_q;
        oku_ptr_d = oku_ptr_q;
        durum_d   = durum_q;
        if (yonlendir) begin
            ps_d      = hedef;
            sayac_d   = '0;
            yaz_ptr_d = '0;
            oku_ptr_d = '0;
            durum_d   = G1_ISTEK;
        end else begin
            if (el_sikisma) begin
                ps_d      = hizali_ps + PS_BIT'(4);
                yaz_ptr_d = (yaz_ptr_q == SON_PTR) ? '0 : yaz_ptr_q + PTR_W'(1);
            end
            if (cikar) begin
                oku_ptr_d = (oku_ptr_q == SON_PTR) ? '0 : oku_ptr_q + PTR_W'(1);
            end
            case ({el_sikisma, cikar})
                2'b10:   sayac_d = sayac_q + CNT_W'(1);
                2'b01:   sayac_d = sayac_q - CNT_W'(1);
                default: sayac_d = sayac_q;
            endcase
            case (durum_q)
                G1_BOSTA: durum_d = G1_ISTEK;
                G1_ISTEK: if (sayac_d == DERINLIK) durum_d = G1_DOLU;
                G1_DOLU:  if (cikar) durum_d = G1_ISTEK;
                default:  durum_d = G1_BOSTA;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            durum_q   <= G1_BOSTA;
            ps_q      <= RESET_PS;
            sayac_q   <= '0;
            yaz_ptr_q <= '0;
            oku_ptr_q <= '0;
        end else begin
            durum_q   <= durum_d;
            ps_q      <= ps_d;
            sayac_q   <= sayac_d;
            yaz_ptr_q <= yaz_ptr_d;
            oku_ptr_q <= oku_ptr_d;
        end
    end

    // Storage needs no reset: entries are only visible while the count covers them.
    always_ff @(posedge clk_i) begin
        if (el_sikisma) begin
            fifo_q[yaz_ptr_q] <= ps_q;
        end
    end

    assign l1b_istek_ps_o      = hizali_ps;
    assign l1b_istek_gecerli_o = istek_gecerli;
    assign g1_istek_yapildi_o  = el_sikisma;
    assign g2_ps_o             = fifo_q[oku_ptr_q];
    assign g2_ps_gecerli_o     = (sayac_q != '0);

endmodule

// File: tb/tb_getir1.sv
// Self-checking bench for getir1: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based reference model.
module tb_getir1;

    localparam int          D      = 2;
    localparam logic [31:0] RST_PS = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] addr;
    logic        valid;
    logic        l1_hazir;
    logic        yapildi;
    logic [31:0] g2ps;
    logic        g2v;
    logic        g2_hazir;
    logic [31:0] gps;
    logic        dal;
    logic [31:0] yps;
    logic        hat;
    logic        stall;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_on = 1'b0;

    // Reference model: current PS, queue of issued PS values, first-cycle-after-reset flag.
    logic [31:0] m_ps;
    logic [31:0] m_q[$];
    bit          m_bosta;

    always #5 clk = ~clk;

    getir1 #(
        .PS_BIT(32),
        .RESET_PS(32'h4000_0000),
        .FIFO_DERINLIK(D)
    ) dut (
        .clk_i(clk),
        .rstn_i(rstn),
        .l1b_istek_ps_o(addr),
        .l1b_istek_gecerli_o(valid),
        .l1b_istek_hazir_i(l1_hazir),
        .g1_istek_yapildi_o(yapildi),
        .g2_ps_o(g2ps),
        .g2_ps_gecerli_o(g2v),
        .g2_ps_hazir_i(g2_hazir),
        .g2_dallanma_ps_i(gps),
        .g2_dallanma_gecerli_i(dal),
        .yurut_ps_i(yps),
        .yurut_hatali_tahmin_i(hat),
        .cek_duraklat_i(stall)
    );

    function automatic bit m_redir();
        return !stall && (hat || dal);
    endfunction

    function automatic bit m_valid();
        return !m_bosta && (m_q.size() < D) && !m_redir();
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_ps    = RST_PS;
        m_q.delete();
        m_bosta = 1'b1;
    endtask

    task automatic tick();
        bit redir, hs, pop;
        @(posedge clk);
        if (!rstn) begin
            model_reset();
        end else begin
            redir = m_redir();
            hs    = m_valid() && l1_hazir;
            pop   = (m_q.size() != 0) && g2_hazir && !redir;
            if (redir) begin
                m_q.delete();
                m_ps = hat ? yps : gps;
            end else begin
                if (pop) void'(m_q.pop_front());
                if (hs) begin
                    m_q.push_back(m_ps);
                    m_ps = {m_ps[31:2], 2'b00} + 32'd4;
                end
            end
            m_bosta = 1'b0;
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (rstn && chk_on) begin
            chk("m_gecerli", 32'(valid), 32'(m_valid()));
            if (m_valid()) chk("m_istek_ps", addr, {m_ps[31:2], 2'b00});
            chk("m_yapildi", 32'(yapildi), 32'(m_valid() && l1_hazir));
            chk("m_g2_gecerli", 32'(g2v), 32'(m_q.size() != 0));
            if (m_q.size() != 0) chk("m_g2_ps", g2ps, m_q[0]);
        end
    end

    initial begin
        rstn = 1'b0; l1_hazir = 1'b1; g2_hazir = 1'b0;
        gps = '0; dal = 1'b0; yps = '0; hat = 1'b0; stall = 1'b0;
        model_reset();
        chk_on = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gecerli", 32'(valid), 32'd0);
        chk("rst_yapildi", 32'(yapildi), 32'd0);
        chk("rst_g2_gecerli", 32'(g2v), 32'd0);
        chk("rst_ps", addr, RST_PS);
        rstn = 1'b1;

        // Fill with no consumer
        #3 chk("t1_bosta", 32'(valid), 32'd0);
        tick();
        #3 chk("t1_req0", addr, 32'h4000_0000); chk("t1_yap0", 32'(yapildi), 32'd1);
        tick();
        #3 chk("t1_req1", addr, 32'h4000_0004); chk("t1_val1", 32'(valid), 32'd1);
        tick();
        g2_hazir = 1'b1;
        #3 chk("t1_full", 32'(valid), 32'd0); chk("t1_head", g2ps, 32'h4000_0000);
        tick();

        // Steady streaming
        for (int i = 0; i < 4; i++) begin
            #3 chk("t2_req", addr, 32'h4000_0008 + 32'(4 * i));
            chk("t2_head", g2ps, 32'h4000_0004 + 32'(4 * i));
            tick();
        end

        // Mispredict with a full FIFO
        g2_hazir = 1'b0;
        #3 tick();
        hat = 1'b1; yps = 32'h8000_0006;
        #3 chk("t3_val", 32'(valid), 32'd0); chk("t3_yap", 32'(yapildi), 32'd0);
        tick();
        hat = 1'b0;
        #3 chk("t3_flush", 32'(g2v), 32'd0); chk("t3_req0", addr, 32'h8000_0004);
        tick();
        #3 chk("t3_head", g2ps, 32'h8000_0006); chk("t3_req1", addr, 32'h8000_0008);
        tick();

        // Redirect priority, then stall masking
        hat = 1'b1; yps = 32'h100; dal = 1'b1; gps = 32'h200; g2_hazir = 1'b1;
        #3 tick();
        hat = 1'b0; dal = 1'b0;
        #3 chk("t4_prio", addr, 32'h100);
        tick();
        hat = 1'b1; dal = 1'b1; stall = 1'b1;
        #3 chk("t4_stall_val", 32'(valid), 32'd1); chk("t4_stall_req", addr, 32'h104);
        tick();
        hat = 1'b0; dal = 1'b0; stall = 1'b0;
        #3 chk("t4_seq", addr, 32'h108);
        tick();

        // Address wrap
        hat = 1'b1; yps = 32'hFFFF_FFFC;
        #3 tick();
        hat = 1'b0;
        #3 chk("t5_top", addr, 32'hFFFF_FFFC);
        tick();
        #3 chk("t5_wrap", addr, 32'h0000_0000); chk("t5_head", g2ps, 32'hFFFF_FFFC);
        tick();

        // Async reset mid-stream
        rstn = 1'b0;
        #1 chk("t6_val", 32'(valid), 32'd0); chk("t6_yap", 32'(yapildi), 32'd0);
        chk("t6_g2v", 32'(g2v), 32'd0); chk("t6_ps", addr, RST_PS);
        tick(); tick();
        rstn = 1'b1;
        #3 chk("t6_bosta", 32'(valid), 32'd0);
        tick();
        #3 chk("t6_req", addr, RST_PS); chk("t6_reqv", 32'(valid), 32'd1);
        tick();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rstn     = ($urandom_range(0, 499) != 0);
            l1_hazir = ($urandom_range(0, 3) != 0);
            g2_hazir = ($urandom_range(0, 2) != 0);
            hat      = ($urandom_range(0, 15) == 0);
            dal      = ($urandom_range(0, 11) == 0);
            stall    = ($urandom_range(0, 7) == 0);
            yps      = $urandom;
            gps      = $urandom;
            tick();
        end

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
